// File: rtl/bmf_stream_decoder.sv
// Streaming decoder for a Boolean-matrix-factorized approximate circuit.
// Each accepted K-bit latent vector is expanded through a run-time programmable
// K x M basis matrix H into an M-bit vector: OR-of-ANDs (mode 0) or XOR-of-ANDs
// (mode 1). Results pass through a 2-entry FIFO to the consumer.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   cfg_we/row/data     write one row of H; cfg_mode is sampled with each legal write
//   cfg_err             one-cycle pulse after a write to a row index >= K
//   in_valid/ready/k    latent vector handshake
//   out_valid/ready/po  reconstructed vector handshake (FIFO head)
//   out_count           vectors delivered since reset (wraps)
module bmf_stream_decoder #(
  parameter int unsigned K     = 3,
  parameter int unsigned M     = 4,
  parameter int unsigned CNT_W = 16,
  localparam int unsigned RW   = (K > 1) ? $clog2(K) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_we,
  input  logic [RW-1:0]    cfg_row,
  input  logic [M-1:0]     cfg_data,
  input  logic             cfg_mode,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [K-1:0]     in_k,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [M-1:0]     out_po,
  output logic             cfg_err,
  output logic [CNT_W-1:0] out_count
);

  typedef enum logic [0:0] {StUnconf, StRun} state_e;

  state_e           state_q;
  logic [M-1:0]     h_q [K];
  logic [K-1:0]     loaded_q, loaded_d;
  logic             mode_q;
  logic [M-1:0]     buf_q [2];
  logic             rd_ptr_q, wr_ptr_q;
  logic [1:0]       occ_q;
  logic             cfg_err_q;
  logic [CNT_W-1:0] count_q;

  logic             row_ok;
  logic             push, pop;
  logic [M-1:0]     result;

  assign row_ok = (32'(cfg_row) < K);

  always_comb begin
    loaded_d = loaded_q;
    if (cfg_we && row_ok) loaded_d[cfg_row] = 1'b1;
  end

  // Uses the pre-edge H and mode, so a write in the same cycle cannot leak in
  // (and in_ready is low during a write anyway).
  always_comb begin
    result = '0;
    for (int unsigned i = 0; i < K; i++) begin
      if (in_k[i]) result = mode_q ? (result ^ h_q[i]) : (result | h_q[i]);
    end
  end

  // Readiness depends only on registered state and cfg_we; no path from out_ready.
  assign in_ready  = (state_q == StRun) && !cfg_we && (occ_q != 2'd2);
  assign out_valid = (occ_q != 2'd0);
  assign out_po    = out_valid ? buf_q[rd_ptr_q] : '0;
  assign cfg_err   = cfg_err_q;
  assign out_count = count_q;

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  // Configuration state and mode/run FSM. RUN is only left through reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < K; i++) h_q[i] <= '0;
      loaded_q  <= '0;
      mode_q    <= 1'b0;
      cfg_err_q <= 1'b0;
      state_q   <= StUnconf;
    end else begin
      if (cfg_we && row_ok) begin
        h_q[cfg_row] <= cfg_data;
        mode_q       <= cfg_mode;
      end
      loaded_q  <= loaded_d;
      cfg_err_q <= cfg_we && !row_ok;
      unique case (state_q)
        StUnconf: if (&loaded_d) state_q <= StRun;
        StRun:    state_q <= StRun;
        default:  state_q <= StUnconf;
      endcase
    end
  end

  // Output FIFO and delivery counter; independent of the FSM state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_q[0] <= '0;
      buf_q[1] <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      occ_q    <= 2'd0;
      count_q  <= '0;
    end else begin
      if (push) begin
        buf_q[wr_ptr_q] <= result;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
        count_q  <= count_q + CNT_W'(1);
      end
      occ_q <= occ_q + 2'(push) - 2'(pop);
    end
  end

endmodule
